// File: rtl/nn_layer_13x16_relu.sv
// nn_layer_13x16_relu: 13x16 fully connected layer with ReLU.
// Takes 16 input words, then runs one multiply-accumulate per cycle against
// a fixed weight ROM. Emits 13 ReLU'd results, one per output handshake.
module nn_layer_13x16_relu (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  input  logic        m_ready,
  input  logic [31:0] data_in,
  output logic        m_valid,
  output logic        s_ready,
  output logic [31:0] data_out
);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  r_m;
  logic [3:0]  r_n;
  logic [31:0] r_acc;
  logic [31:0] r_x [16];
  logic        r_m_valid;
  logic        r_s_ready;
  logic [31:0] r_data_out;

  logic        w_accept;
  logic        w_out_hs;
  logic        w_last_word;
  logic        w_last_col;
  logic        w_last_row;
  logic [31:0] w_weight;
  logic [31:0] w_prod;
  logic [31:0] w_sum;
  logic [31:0] w_relu;

  assign w_accept    = r_s_ready & s_valid & (r_state == LOAD);
  assign w_out_hs    = r_m_valid & m_ready & (r_state == OUTPUT);
  assign w_last_word = (r_cnt == 4'd15);
  assign w_last_col  = (r_n == 4'd15);
  assign w_last_row  = (r_m == 4'd12);

  // {m, n} concatenated is exactly 16*m + n, so the ROM is a subtraction.
  assign w_weight = {24'd0, r_m, r_n} - 32'd100;
  // Low 32 bits of the product are the same for signed and unsigned operands.
  assign w_prod   = w_weight * r_x[r_n];
  assign w_sum    = r_acc + w_prod;
  assign w_relu   = w_sum[31] ? 32'd0 : w_sum;

  assign m_valid  = r_m_valid;
  assign s_ready  = r_s_ready;
  assign data_out = r_data_out;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      LOAD: begin
        if (w_accept && w_last_word) begin
          w_state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        if (w_last_col) begin
          w_state_next = OUTPUT;
        end
      end
      OUTPUT: begin
        if (w_out_hs) begin
          w_state_next = w_last_row ? LOAD : COMPUTE;
        end
      end
      default: w_state_next = LOAD;
    endcase
  end

  // Counters, accumulator, handshake flags and the output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= 4'd0;
      r_m        <= 4'd0;
      r_n        <= 4'd0;
      r_acc      <= 32'd0;
      r_m_valid  <= 1'b0;
      r_s_ready  <= 1'b0;
      r_data_out <= 32'd0;
    end else begin
      case (r_state)
        LOAD: begin
          // Ready comes up one edge after reset and stays up until word 15.
          r_s_ready <= 1'b1;
          if (w_accept) begin
            r_cnt <= r_cnt + 4'd1;
            if (w_last_word) begin
              r_s_ready <= 1'b0;
              r_m       <= 4'd0;
              r_n       <= 4'd0;
              r_acc     <= 32'd0;
            end
          end
        end
        COMPUTE: begin
          r_acc <= w_sum;
          r_n   <= r_n + 4'd1;
          if (w_last_col) begin
            r_data_out <= w_relu;
            r_m_valid  <= 1'b1;
          end
        end
        OUTPUT: begin
          if (w_out_hs) begin
            r_m_valid <= 1'b0;
            if (w_last_row) begin
              r_s_ready <= 1'b1;
              r_cnt     <= 4'd0;
              r_m       <= 4'd0;
            end else begin
              r_m   <= r_m + 4'd1;
              r_acc <= 32'd0;
              r_n   <= 4'd0;
            end
          end
        end
        default: begin
          r_s_ready <= 1'b0;
          r_m_valid <= 1'b0;
        end
      endcase
    end
  end

  // Input buffer: no reset needed, every word is rewritten before it is used.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_x[r_cnt] <= data_in;
    end
  end

endmodule

// File: tb/tb_nn_layer_13x16_relu.sv
// Self-checking bench for nn_layer_13x16_relu: directed vectors, random
// stalled streams and mid-operation resets, checked against a dot-product model.
module tb_nn_layer_13x16_relu;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        m_ready;
  logic [31:0] data_in;
  logic        m_valid;
  logic        s_ready;
  logic [31:0] data_out;

  int total = 0;
  int bad   = 0;
  int in_q[$];
  int exp_q[$];
  int words_in = 0;
  int outs = 0;
  int cyc = 0;
  int ref_edge = 0;

  nn_layer_13x16_relu dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .m_ready  (m_ready),
    .data_in  (data_in),
    .m_valid  (m_valid),
    .s_ready  (s_ready),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  // y[m] = ReLU(sum_n (16m + n - 100) * x[n]) with 32-bit wrapping int math.
  function automatic int model_row(input int x[16], input int m);
    int acc;
    acc = 0;
    for (int n = 0; n < 16; n++) begin
      acc = acc + (16 * m + n - 100) * x[n];
    end
    return (acc < 0) ? 0 : acc;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_vec(input int x[16]);
    for (int n = 0; n < 16; n++) in_q.push_back(x[n]);
    for (int m = 0; m < 13; m++) exp_q.push_back(model_row(x, m));
  endtask

  // Runs the stream until both queues empty (or, with hold_out, until the
  // first result is presented while m_ready is held low).
  task automatic drain(input int pct_stall, input int budget, input bit hold_out);
    bit          prev_stall = 0;
    bit          prev_mv = 0;
    bit          after_last = 0;
    logic [31:0] prev_data = 0;
    bit          hs_in;
    bit          hs_out;
    int          n_cyc = 0;
    while ((in_q.size() > 0 || exp_q.size() > 0) && n_cyc < budget) begin
      @(negedge clk);
      if (hold_out && m_valid) break;
      if (prev_stall) begin
        check("hold_valid", m_valid, 1'b1);
        check("hold_data", data_out, prev_data);
      end
      if (after_last) check("s_ready_after_last", s_ready, 1'b1);
      if (m_valid && !prev_mv) check("latency", cyc - ref_edge, 16);
      if (s_ready) check("ready_exclusive", m_valid, 1'b0);
      s_valid = (in_q.size() > 0) && ($urandom_range(99) >= pct_stall);
      data_in = s_valid ? in_q[0] : $urandom;
      m_ready = hold_out ? 1'b0 : ($urandom_range(99) >= pct_stall);
      hs_in  = s_valid && s_ready;
      hs_out = m_valid && m_ready;
      if (hs_out) begin
        if (exp_q.size() > 0) begin
          check($sformatf("y%0d", outs % 13), data_out, exp_q.pop_front());
        end else begin
          total++;
          assert (exp_q.size() > 0)
          else begin
            bad++;
            $error("FAIL extra_output observed=%h expected=none", data_out);
          end
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = data_out;
      prev_mv    = m_valid;
      after_last = 0;
      @(posedge clk);
      cyc++;
      n_cyc++;
      if (hs_in) begin
        void'(in_q.pop_front());
        words_in++;
        if (words_in % 16 == 0) ref_edge = cyc;
      end
      if (hs_out) begin
        outs++;
        ref_edge = cyc;
        if (outs % 13 == 0) after_last = 1;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b0;
    if (hold_out) begin
      check("reach_output", m_valid, 1'b1);
    end else begin
      if (after_last) check("s_ready_after_last", s_ready, 1'b1);
      check("stream_complete", in_q.size() + exp_q.size(), 0);
    end
  endtask

  // Assert reset from a negedge, check outputs clear, then release.
  task automatic do_reset(input string tag);
    @(negedge clk);
    reset   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    check({tag, "_m_valid"}, m_valid, 1'b0);
    check({tag, "_s_ready"}, s_ready, 1'b0);
    check({tag, "_data_out"}, data_out, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_m_valid_held"}, m_valid, 1'b0);
    check({tag, "_s_ready_held"}, s_ready, 1'b0);
    reset = 1'b1;
    in_q.delete();
    exp_q.delete();
    words_in = 0;
    outs = 0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check({tag, "_s_ready_rise"}, s_ready, 1'b1);
  endtask

  initial begin
    int v[16];
    int sent;
    int guard;
    reset   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    data_in = 32'd0;

    // Reset state.
    repeat (2) @(posedge clk);
    do_reset("por");

    // All-zero vector.
    foreach (v[i]) v[i] = 0;
    push_vec(v);
    drain(0, 400, 0);

    // Unit vector.
    foreach (v[i]) v[i] = 0;
    v[0] = 1;
    push_vec(v);
    drain(0, 400, 0);

    // All-ones vector.
    foreach (v[i]) v[i] = 1;
    push_vec(v);
    drain(0, 400, 0);

    // Wraparound on the first product.
    foreach (v[i]) v[i] = 0;
    v[0] = 32'h7FFF_FFFF;
    push_vec(v);
    drain(0, 400, 0);

    // Random vectors with ~50% stalls on both sides.
    for (int k = 0; k < 40; k++) begin
      foreach (v[i]) v[i] = (k % 2 == 0) ? $urandom : $urandom_range(2000) - 1000;
      push_vec(v);
    end
    drain(50, 40 * 700, 0);

    // Reset after 7 accepted inputs, then a fresh vector.
    sent = 0;
    guard = 0;
    while (sent < 7 && guard < 30) begin
      @(negedge clk);
      s_valid = 1'b1;
      data_in = $urandom;
      if (s_ready) sent++;
      guard++;
    end
    check("partial_sent", sent, 7);
    do_reset("rst_load");
    foreach (v[i]) v[i] = $urandom_range(500) - 250;
    push_vec(v);
    drain(30, 1000, 0);

    // Reset while a result is pending in OUTPUT, then a fresh vector.
    foreach (v[i]) v[i] = $urandom;
    push_vec(v);
    drain(0, 60, 1);
    do_reset("rst_output");
    foreach (v[i]) v[i] = $urandom;
    push_vec(v);
    drain(20, 1000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
